// File: rtl/toy_bus_pkg.sv
// Shared ToyBusAck definitions: default field widths and the packed ack payload.
package toy_bus_pkg;

    localparam int unsigned TOY_BUS_ID_W   = 4;
    localparam int unsigned TOY_BUS_DATA_W = 256;
    localparam int unsigned TOY_BUS_SB_W   = 32;

    typedef struct packed {
        logic                      opcode;
        logic [TOY_BUS_DATA_W-1:0] data;
        logic [TOY_BUS_SB_W-1:0]   sideband;
        logic [TOY_BUS_ID_W-1:0]   src_id;
        logic [TOY_BUS_ID_W-1:0]   tgt_id;
    } toy_bus_ack_t;

    localparam int unsigned TOY_BUS_ACK_W = $bits(toy_bus_ack_t);

endpackage

// File: rtl/toy_bus_wrap_ptr.sv
// Circular index register that steps by one on inc and wraps explicitly at DEPTH-1,
// so non-power-of-two depths work.
module toy_bus_wrap_ptr #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/toy_bus_ack_slice_fifo.sv
// First-word-fall-through decoupling FIFO behind the ToyBusAck arbiter; in0_rdy comes
// from stored state only, which cuts the arbiter's combinational ready path.
module toy_bus_ack_slice_fifo
    import toy_bus_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = TOY_BUS_DATA_W,
    parameter  int unsigned SB_W   = TOY_BUS_SB_W,
    parameter  int unsigned ID_W   = TOY_BUS_ID_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic              in0_opcode,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [SB_W-1:0]   in0_sideband,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,
    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic              out0_opcode,
    output logic [DATA_W-1:0] out0_data,
    output logic [SB_W-1:0]   out0_sideband,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned PAY_W = 1 + DATA_W + SB_W + 2 * ID_W;

    logic [PAY_W-1:0] mem_q [DEPTH];
    logic [PAY_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PAY_W-1:0] pay_in;
    logic             push;
    logic             pop;

    assign pay_in = {in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id};

    // Ready is gated by reset so nothing is taken while the queue is being cleared.
    assign in0_rdy  = ~rst & (cnt_q != CNT_W'(DEPTH));
    assign out0_vld = (cnt_q != '0);
    assign push     = in0_vld & in0_rdy;
    assign pop      = out0_vld & out0_rdy;

    toy_bus_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .ptr (wr_ptr)
    );

    toy_bus_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .ptr (rd_ptr)
    );

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[wr_ptr] = pay_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    // Head is read straight from storage; stale when empty and qualified by out0_vld.
    assign {out0_opcode, out0_data, out0_sideband, out0_src_id, out0_tgt_id} = mem_q[rd_ptr];
    assign occupancy = cnt_q;

endmodule

// File: tb/tb_toy_bus_ack_slice_fifo.sv
// Bench for toy_bus_ack_slice_fifo: directed table, hand sequences and a random run
// against queue models, on a DEPTH=4 and a DEPTH=3 instance sharing the inputs.
module tb_toy_bus_ack_slice_fifo;
    import toy_bus_pkg::*;

    localparam int unsigned DA = 4;
    localparam int unsigned DB = 3;
    localparam int unsigned CA_W = $clog2(DA + 1);
    localparam int unsigned CB_W = $clog2(DB + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_vld;
    logic        out0_rdy;
    toy_bus_ack_t pin;

    logic         a_in0_rdy, a_out0_vld, b_in0_rdy, b_out0_vld;
    toy_bus_ack_t a_head, b_head;
    logic [CA_W-1:0] a_occ;
    logic [CB_W-1:0] b_occ;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    toy_bus_ack_slice_fifo #(.DEPTH(DA)) dut_a (
        .clk(clk), .rst(rst),
        .in0_vld(in0_vld), .in0_rdy(a_in0_rdy),
        .in0_opcode(pin.opcode), .in0_data(pin.data), .in0_sideband(pin.sideband),
        .in0_src_id(pin.src_id), .in0_tgt_id(pin.tgt_id),
        .out0_vld(a_out0_vld), .out0_rdy(out0_rdy),
        .out0_opcode(a_head.opcode), .out0_data(a_head.data), .out0_sideband(a_head.sideband),
        .out0_src_id(a_head.src_id), .out0_tgt_id(a_head.tgt_id),
        .occupancy(a_occ)
    );

    toy_bus_ack_slice_fifo #(.DEPTH(DB)) dut_b (
        .clk(clk), .rst(rst),
        .in0_vld(in0_vld), .in0_rdy(b_in0_rdy),
        .in0_opcode(pin.opcode), .in0_data(pin.data), .in0_sideband(pin.sideband),
        .in0_src_id(pin.src_id), .in0_tgt_id(pin.tgt_id),
        .out0_vld(b_out0_vld), .out0_rdy(out0_rdy),
        .out0_opcode(b_head.opcode), .out0_data(b_head.data), .out0_sideband(b_head.sideband),
        .out0_src_id(b_head.src_id), .out0_tgt_id(b_head.tgt_id),
        .occupancy(b_occ)
    );

    function automatic toy_bus_ack_t mk(input int tag);
        toy_bus_ack_t p;
        logic [31:0]  t;
        t          = 32'(tag);
        p.opcode   = t[0];
        p.data     = {8{t ^ 32'h5A5A_0000}};
        p.sideband = t * 32'd7;
        p.src_id   = t[3:0];
        p.tgt_id   = t[7:4];
        return p;
    endfunction

    task automatic chk(input string nm, input logic [TOY_BUS_ACK_W-1:0] got,
                       input logic [TOY_BUS_ACK_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input toy_bus_ack_t p);
        in0_vld  = v;
        out0_rdy = r;
        pin      = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic v;
        logic r;
        int   tag;
        logic e_rdy;
        logic e_vld;
        int   e_occ;
        int   e_tag;   // -1: head not checked
    } vec_t;

    vec_t vec [14];
    toy_bus_ack_t qa [$];
    toy_bus_ack_t qb [$];
    toy_bus_ack_t sp;

    initial begin
        // Fill to full, blocked 5th beat, pop frees a slot next cycle, drain, empty ignores rdy.
        vec[0]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 0, -1};
        vec[1]  = '{1'b1, 1'b0, 2, 1'b1, 1'b1, 1,  1};
        vec[2]  = '{1'b1, 1'b0, 3, 1'b1, 1'b1, 2,  1};
        vec[3]  = '{1'b1, 1'b0, 4, 1'b1, 1'b1, 3,  1};
        vec[4]  = '{1'b1, 1'b0, 5, 1'b0, 1'b1, 4,  1};
        vec[5]  = '{1'b1, 1'b1, 5, 1'b0, 1'b1, 4,  1};
        vec[6]  = '{1'b1, 1'b0, 5, 1'b1, 1'b1, 3,  2};
        vec[7]  = '{1'b0, 1'b1, 0, 1'b0, 1'b1, 4,  2};
        vec[8]  = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 3,  3};
        vec[9]  = '{1'b1, 1'b1, 6, 1'b1, 1'b1, 2,  4};
        vec[10] = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 2,  5};
        vec[11] = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 1,  6};
        vec[12] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 0, -1};
        vec[13] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 0, -1};

        rst = 1'b1;
        drive(1'b0, 1'b0, mk(0));
        tick();
        tick();
        chk("rst_in0_rdy", a_in0_rdy, 0);
        chk("rst_out0_vld", a_out0_vld, 0);
        chk("rst_occ", a_occ, 0);
        chk("rst_head_zero", a_head, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in0_rdy", a_in0_rdy, 1);
        tick();
        chk("idle_in0_rdy", a_in0_rdy, 1);
        chk("idle_out0_vld", a_out0_vld, 0);
        chk("idle_occ", a_occ, 0);

        // Directed table on the DEPTH=4 instance.
        for (int i = 0; i < 14; i++) begin
            drive(vec[i].v, vec[i].r, mk(vec[i].tag));
            #1;
            chk($sformatf("tbl%0d_in0_rdy", i), a_in0_rdy, vec[i].e_rdy);
            chk($sformatf("tbl%0d_out0_vld", i), a_out0_vld, vec[i].e_vld);
            chk($sformatf("tbl%0d_occ", i), a_occ, vec[i].e_occ);
            if (vec[i].e_tag >= 0) chk($sformatf("tbl%0d_head", i), a_head, mk(vec[i].e_tag));
            tick();
        end

        // Single beat: next-cycle visibility and hold until accepted.
        sp          = mk(0);
        sp.opcode   = 1'b1;
        sp.data     = {32{8'hA5}};
        sp.sideband = 32'h0000_1234;
        sp.src_id   = 4'd3;
        sp.tgt_id   = 4'd9;
        drive(1'b1, 1'b0, sp);
        tick();
        drive(1'b0, 1'b0, mk(77));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("single_vld%0d", i), a_out0_vld, 1);
            chk($sformatf("single_hold%0d", i), a_head, sp);
            tick();
        end
        out0_rdy = 1'b1;
        tick();
        out0_rdy = 1'b0;
        chk("single_occ_after_pop", a_occ, 0);
        chk("single_vld_after_pop", a_out0_vld, 0);

        // Streaming: one beat per cycle, occupancy steady at 1.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, mk(100 + i));
            #1;
            chk($sformatf("stream%0d_in0_rdy", i), a_in0_rdy, 1);
            chk($sformatf("stream%0d_occ", i), a_occ, (i == 0) ? 0 : 1);
            if (i > 0) chk($sformatf("stream%0d_head", i), a_head, mk(100 + i - 1));
            tick();
        end
        drive(1'b0, 1'b1, mk(0));
        tick();
        chk("stream_drained", a_occ, 0);

        // Async reset with three queued beats.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, mk(200 + i));
            tick();
        end
        drive(1'b0, 1'b0, mk(0));
        chk("pre_rst_occ", a_occ, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_vld_a", a_out0_vld, 0);
        chk("async_rst_vld_b", b_out0_vld, 0);
        chk("async_rst_occ", a_occ, 0);
        chk("async_rst_in0_rdy", a_in0_rdy, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            out0_rdy = 1'b1;
            #1;
            chk($sformatf("post_rst%0d_vld", i), a_out0_vld, 0);
            chk($sformatf("post_rst%0d_occ", i), a_occ, 0);
            chk($sformatf("post_rst%0d_rdy", i), a_in0_rdy, 1);
            tick();
        end

        // Random traffic against queue models on both depths (DEPTH=3 exercises the wrap).
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic v, r, pa, pb, oa, ob;
            toy_bus_ack_t p;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 1) != 0);
            p = mk(1000 + i);
            drive(v, r, p);
            #1;
            chk("rnd_a_rdy", a_in0_rdy, qa.size() != DA);
            chk("rnd_a_vld", a_out0_vld, qa.size() != 0);
            chk("rnd_a_occ", a_occ, qa.size());
            if (qa.size() != 0) chk("rnd_a_head", a_head, qa[0]);
            chk("rnd_b_rdy", b_in0_rdy, qb.size() != DB);
            chk("rnd_b_vld", b_out0_vld, qb.size() != 0);
            chk("rnd_b_occ", b_occ, qb.size());
            if (qb.size() != 0) chk("rnd_b_head", b_head, qb[0]);
            pa = v && (qa.size() != DA);
            oa = r && (qa.size() != 0);
            pb = v && (qb.size() != DB);
            ob = r && (qb.size() != 0);
            tick();
            if (oa) void'(qa.pop_front());
            if (pa) qa.push_back(p);
            if (ob) void'(qb.pop_front());
            if (pb) qb.push_back(p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
